// File: rtl/rgb_fade_pkg.sv
// Shared types for the colour-fade sequencer: ramp states, mode codes and the
// 8-bit peak colour table.
package rgb_fade_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    FALL  = 2'd2,
    SOLID = 2'd3
  } state_t;

  localparam logic [1:0] MODE_CYCLE   = 2'd0;
  localparam logic [1:0] MODE_BREATHE = 2'd1;
  localparam logic [1:0] MODE_SOLID   = 2'd2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  function automatic rgb8_t peak8(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{r: 8'd255, g: 8'd0,   b: 8'd0};    // red
      3'd1:    return '{r: 8'd255, g: 8'd60,  b: 8'd0};    // orange
      3'd2:    return '{r: 8'd255, g: 8'd255, b: 8'd0};    // yellow
      3'd3:    return '{r: 8'd0,   g: 8'd255, b: 8'd0};    // green
      3'd4:    return '{r: 8'd0,   g: 8'd0,   b: 8'd255};  // blue
      3'd5:    return '{r: 8'd75,  g: 8'd0,   b: 8'd130};  // indigo
      3'd6:    return '{r: 8'd160, g: 8'd32,  b: 8'd240};  // purple
      default: return '{r: 8'd255, g: 8'd255, b: 8'd255};  // white
    endcase
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_tick_divider.sv
// Ramp tick generator: tick is high (combinationally) in the cycle cnt == DIV-1.
// Counter freezes while en is low and resumes from the held value.
module tick_divider #(
  parameter int DIV = 625000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Brightness ramp x colour table -> registered R/G/B duty values.
// lvl/state move on the tick edge; duty lags lvl by one cycle; en=0 freezes everything.
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DIV    = 625000,
  parameter int NCOLOR = 7,
  parameter int STEP   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [2:0]    sel_color,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic [2:0]    color_idx,
  output logic          ramp_up,
  output logic          wrap
);

  localparam logic [DW-1:0] MAX    = '1;
  localparam logic [2:0]    LAST   = 3'(NCOLOR - 1);
  localparam logic [DW:0]   STEP_W = (DW + 1)'(STEP);

  // Repeat the 8-bit pattern down the word so peaks keep full scale at any DW.
  function automatic logic [DW-1:0] widen(input logic [7:0] v);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++)
      w[i] = v[7 - ((DW - 1 - i) % 8)];
    return w;
  endfunction

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] pk, input logic [DW-1:0] l);
    logic [2*DW-1:0] prod;
    prod = (2*DW)'(pk) * ((2*DW)'(l) + (2*DW)'(1));
    return prod[2*DW-1:DW];
  endfunction

  logic          tick;
  state_t        state;
  logic [DW-1:0] lvl;
  logic [2:0]    sel_c;
  logic [DW:0]   lvl_up;
  logic [DW-1:0] lvl_rise;
  logic [DW-1:0] lvl_fall;
  logic [2:0]    next_color;
  logic          next_wrap;
  rgb8_t         pk8;

  tick_divider #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign sel_c    = (sel_color > LAST) ? LAST : sel_color;
  assign lvl_up   = {1'b0, lvl} + STEP_W;
  assign lvl_rise = (lvl_up > {1'b0, MAX}) ? MAX : lvl_up[DW-1:0];
  assign lvl_fall = (lvl < DW'(STEP)) ? '0 : lvl - DW'(STEP);

  // Mode 3 falls through to cycling behaviour.
  always_comb begin
    next_color = (color_idx == LAST) ? 3'd0 : color_idx + 3'd1;
    next_wrap  = (color_idx == LAST);
    if (mode == MODE_BREATHE) begin
      next_color = sel_c;
      next_wrap  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lvl       <= '0;
      color_idx <= '0;
      ramp_up   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (en) begin
        if (mode == MODE_SOLID) begin
          state     <= SOLID;
          lvl       <= MAX;
          color_idx <= sel_c;
          ramp_up   <= 1'b0;
        end else if (state == SOLID) begin
          state   <= RISE;
          lvl     <= '0;
          ramp_up <= 1'b1;
        end else if (tick) begin
          case (state)
            IDLE, RISE: begin
              lvl     <= lvl_rise;
              state   <= (lvl_rise == MAX) ? FALL : RISE;
              ramp_up <= (lvl_rise != MAX);
            end
            FALL: begin
              lvl <= lvl_fall;
              if (lvl_fall == '0) begin
                state     <= RISE;
                ramp_up   <= 1'b1;
                color_idx <= next_color;
                wrap      <= next_wrap;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign pk8 = peak8(color_idx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      duty_r <= '0;
      duty_g <= '0;
      duty_b <= '0;
    end else if (en) begin
      duty_r <= scale(widen(pk8.r), lvl);
      duty_g <= scale(widen(pk8.g), lvl);
      duty_b <= scale(widen(pk8.b), lvl);
    end
  end

endmodule
